wb_stage: RTL

- Write-back stage of the core.
- Collects single-cycle ALU results and out-of-order-in-time (but in-order) LSU load responses.
- Aligns and extends load data, arbitrates between the two sources, and drives the register file's single write port through a registered output.
- Keeps a small FIFO of outstanding-load metadata and exports scoreboard busy flags so decode can stall on load-use hazards.

---
 rtl/wb_stage_pkg.sv | 28 ++
 rtl/wb_stage_if.sv | 56 +++++
 rtl/wb_stage_ld_align.sv | 32 +++
 rtl/wb_stage.sv | 128 ++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the write-back stage.
//   XLEN / RA_W : data word and register address widths
//   ld_size_e   : load access size
//   ld_meta_t   : per-load metadata held until the LSU response arrives
package wb_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RA_W = 5;

    typedef enum logic [1:0] {
        LD_B = 2'b00,
        LD_H = 2'b01,
        LD_W = 2'b10
    } ld_size_e;

    typedef struct packed {
        logic [RA_W-1:0] rd;
        ld_size_e        size;
        logic            is_unsigned;
        logic [1:0]      offset;
    } ld_meta_t;

    // Encoding 2'b11 is not a legal size; it behaves as a word access.
    function automatic ld_size_e decode_size(input logic [1:0] raw);
        return (raw == 2'b11) ? LD_W : ld_size_e'(raw);
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Bundle of all non-clock signals of the write-back stage.
//   slave  : seen from wb_stage (ALU/LSU/decode inputs, RF write port outputs)
//   master : seen from the surrounding pipeline / bench
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic            alu_valid_i;
    logic [RA_W-1:0] alu_rd_i;
    logic [XLEN-1:0] alu_data_i;
    logic            alu_stall_o;

    logic            ld_issue_i;
    logic [RA_W-1:0] ld_rd_i;
    logic [1:0]      ld_size_i;
    logic            ld_unsigned_i;
    logic [1:0]      ld_offset_i;
    logic            ld_issue_ready_o;

    logic            rsp_valid_i;
    logic [XLEN-1:0] rsp_data_i;
    logic            rsp_ready_o;

    logic [RA_W-1:0] rs1_addr_i;
    logic [RA_W-1:0] rs2_addr_i;
    logic            rs1_busy_o;
    logic            rs2_busy_o;

    logic            rf_we_o;
    logic [RA_W-1:0] rf_waddr_o;
    logic [XLEN-1:0] rf_wdata_o;

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        output alu_stall_o,
        input  ld_issue_i, ld_rd_i, ld_size_i, ld_unsigned_i, ld_offset_i,
        output ld_issue_ready_o,
        input  rsp_valid_i, rsp_data_i,
        output rsp_ready_o,
        input  rs1_addr_i, rs2_addr_i,
        output rs1_busy_o, rs2_busy_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o
    );

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        input  alu_stall_o,
        output ld_issue_i, ld_rd_i, ld_size_i, ld_unsigned_i, ld_offset_i,
        input  ld_issue_ready_o,
        output rsp_valid_i, rsp_data_i,
        input  rsp_ready_o,
        output rs1_addr_i, rs2_addr_i,
        input  rs1_busy_o, rs2_busy_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o
    );

endinterface

// File: rtl/wb_stage_ld_align.sv
// Load data alignment: shifts the raw memory word down by the byte offset and
// sign/zero-extends the selected byte or halfword.
//   raw         : word as returned by memory
//   size        : access size
//   is_unsigned : zero-extend when 1
//   offset      : addr[1:0]
//   result      : aligned, extended value
module wb_stage_ld_align
    import wb_stage_pkg::*;
(
    input  logic [XLEN-1:0] raw,
    input  ld_size_e        size,
    input  logic            is_unsigned,
    input  logic [1:0]      offset,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    // A halfword at offset 3 gets zeros shifted into its top byte; no trap.
    assign shifted = raw >> {offset, 3'b000};

    always_comb begin
        result = shifted;
        unique case (size)
            LD_B: result = {{(XLEN-8){shifted[7] & ~is_unsigned}}, shifted[7:0]};
            LD_H: result = {{(XLEN-16){shifted[15] & ~is_unsigned}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage. Arbitrates ALU results against in-order LSU load
// responses (loads win), aligns load data and drives the register file write
// port through one register stage. A small FIFO holds metadata of outstanding
// loads and doubles as the load-use scoreboard for decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ALU input, load issue, LSU response, scoreboard query and
//                register file write port (see wb_stage_if)
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned LD_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_stage_if.slave   bus
);

    localparam int unsigned PtrW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(LD_DEPTH + 1);

    ld_meta_t              meta_q [LD_DEPTH];
    logic [LD_DEPTH-1:0]   vld_q;
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [CntW-1:0]       cnt_q;

    logic                  rf_we_q;
    logic [RA_W-1:0]       rf_waddr_q;
    logic [XLEN-1:0]       rf_wdata_q;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    ld_meta_t              push_meta;
    ld_meta_t              head;
    logic [XLEN-1:0]       ld_data;

    logic                  win_valid;
    logic [RA_W-1:0]       win_rd;
    logic [XLEN-1:0]       win_data;
    logic                  rs1_hit;
    logic                  rs2_hit;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(LD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (cnt_q == CntW'(LD_DEPTH));
    assign empty = (cnt_q == '0);
    // Issue while full is dropped; a same-cycle pop does not make room.
    assign push  = bus.ld_issue_i && !full;
    assign pop   = bus.rsp_valid_i && !empty;

    assign push_meta = '{rd:          bus.ld_rd_i,
                         size:        decode_size(bus.ld_size_i),
                         is_unsigned: bus.ld_unsigned_i,
                         offset:      bus.ld_offset_i};
    assign head = meta_q[rd_ptr_q];

    wb_stage_ld_align u_ld_align (
        .raw         (bus.rsp_data_i),
        .size        (head.size),
        .is_unsigned (head.is_unsigned),
        .offset      (head.offset),
        .result      (ld_data)
    );

    // A retiring load always takes the write port; the ALU is told to hold.
    assign win_valid = pop || bus.alu_valid_i;
    assign win_rd    = pop ? head.rd : bus.alu_rd_i;
    assign win_data  = pop ? ld_data : bus.alu_data_i;

    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (vld_q[i] && (meta_q[i].rd == bus.rs1_addr_i)) rs1_hit = 1'b1;
            if (vld_q[i] && (meta_q[i].rd == bus.rs2_addr_i)) rs2_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LD_DEPTH; i++) meta_q[i] <= '0;
            vld_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            // Push and pop never address the same slot: a pop needs a
            // non-empty FIFO and a push needs a non-full one.
            if (push) begin
                meta_q[wr_ptr_q] <= push_meta;
                vld_q[wr_ptr_q]  <= 1'b1;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end

            rf_we_q <= win_valid && (win_rd != '0);
            if (win_valid) begin
                rf_waddr_q <= win_rd;
                rf_wdata_q <= win_data;
            end
        end
    end

    assign bus.alu_stall_o      = bus.alu_valid_i && pop;
    assign bus.ld_issue_ready_o = !full;
    assign bus.rsp_ready_o      = !empty;
    assign bus.rs1_busy_o       = (bus.rs1_addr_i != '0) && rs1_hit;
    assign bus.rs2_busy_o       = (bus.rs2_addr_i != '0) && rs2_hit;
    assign bus.rf_we_o          = rf_we_q;
    assign bus.rf_waddr_o       = rf_waddr_q;
    assign bus.rf_wdata_o       = rf_wdata_q;

endmodule
